// File: rtl/cache_tag_ctrl.sv
// N-way set-associative tag controller: lookup, victim choice, refill handshake and tag write-back.
// Define CACHE_TAG_STATS_EN to add 32-bit hit/miss counters (hit_cnt, miss_cnt).
module cache_tag_ctrl #(
    parameter int N       = 2,
    parameter int LOG_N   = 1,
    parameter int H       = 64,
    parameter int LOG_H   = 6,
    parameter int TAG_LEN = 20
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LOG_H-1:0]     req_index,
    input  logic [TAG_LEN-1:0]   req_tag,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [LOG_N-1:0]     resp_way,
    output logic [LOG_H-1:0]     tr_addr,
    output logic [N-1:0]         tr_we,
    output logic [TAG_LEN-1:0]   tr_din,
    input  logic [N*TAG_LEN-1:0] tr_dout,
    output logic                 rf_req_valid,
    input  logic                 rf_req_ready,
    input  logic                 rf_done
`ifdef CACHE_TAG_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        UPDATE,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [LOG_H-1:0]     index_q, index_d;
    logic [TAG_LEN-1:0]   tag_q, tag_d;
    logic [LOG_N-1:0]     victim_q, victim_d;
    logic                 from_rr_q, from_rr_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [LOG_N-1:0]     resp_way_q, resp_way_d;
    logic [LOG_N-1:0]     rr_q, rr_d;
    logic [N-1:0]         valid_q [H];
    logic [N-1:0]         valid_d [H];

    logic                 hit_any;
    logic [LOG_N-1:0]     hit_way;
    logic                 inv_any;
    logic [LOG_N-1:0]     inv_way;

`ifdef CACHE_TAG_STATS_EN
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            index_q    <= '0;
            tag_q      <= '0;
            victim_q   <= '0;
            from_rr_q  <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
            rr_q       <= '0;
            for (int i = 0; i < H; i++) begin
                valid_q[i] <= '0;
            end
`ifdef CACHE_TAG_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            victim_q   <= victim_d;
            from_rr_q  <= from_rr_d;
            resp_hit_q <= resp_hit_d;
            resp_way_q <= resp_way_d;
            rr_q       <= rr_d;
            valid_q    <= valid_d;
`ifdef CACHE_TAG_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    // Scan downward so the lowest-numbered matching / invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (valid_q[index_q][j] && (tr_dout[j*TAG_LEN +: TAG_LEN] == tag_q)) begin
                hit_any = 1'b1;
                hit_way = LOG_N'(j);
            end
            if (!valid_q[index_q][j]) begin
                inv_any = 1'b1;
                inv_way = LOG_N'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (req_valid)    state_d = LOOKUP;
            LOOKUP:      state_d = hit_any ? RESP : REFILL_REQ;
            REFILL_REQ:  if (rf_req_ready) state_d = REFILL_WAIT;
            REFILL_WAIT: if (rf_done)      state_d = UPDATE;
            UPDATE:      state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        index_d    = index_q;
        tag_d      = tag_q;
        victim_d   = victim_q;
        from_rr_d  = from_rr_q;
        resp_hit_d = resp_hit_q;
        resp_way_d = resp_way_q;
        rr_d       = rr_q;
        valid_d    = valid_q;
`ifdef CACHE_TAG_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    index_d = req_index;
                    tag_d   = req_tag;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = hit_way;
                end else begin
                    victim_d  = inv_any ? inv_way : rr_q;
                    from_rr_d = !inv_any;
                end
            end
            UPDATE: begin
                valid_d[index_q][victim_q] = 1'b1;
                resp_hit_d = 1'b0;
                resp_way_d = victim_q;
                if (from_rr_q) begin
                    rr_d = (rr_q == LOG_N'(N - 1)) ? '0 : rr_q + LOG_N'(1);
                end
            end
            RESP: begin
`ifdef CACHE_TAG_STATS_EN
                if (resp_hit_q) hit_cnt_d  = hit_cnt_q + 32'd1;
                else            miss_cnt_d = miss_cnt_q + 32'd1;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE) && resetn;
        resp_valid   = (state_q == RESP);
        resp_hit     = resp_hit_q;
        resp_way     = resp_way_q;
        tr_addr      = (state_q == IDLE) ? req_index : index_q;
        tr_we        = (state_q == UPDATE) ? (N'(1) << victim_q) : '0;
        tr_din       = tag_q;
        rf_req_valid = (state_q == REFILL_REQ);
    end

`ifdef CACHE_TAG_STATS_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed vector table, abort-on-reset sequence,
// randomized lookups against a set/way reference model, and counter checks when CACHE_TAG_STATS_EN is set.
module tb_cache_tag_ctrl;

   localparam int N       = 2;
   localparam int LOG_N   = 1;
   localparam int H       = 64;
   localparam int LOG_H   = 6;
   localparam int TAG_LEN = 20;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [LOG_H-1:0]     req_index = '0;
   logic [TAG_LEN-1:0]   req_tag = '0;
   logic                 resp_valid;
   logic                 resp_hit;
   logic [LOG_N-1:0]     resp_way;
   logic [LOG_H-1:0]     tr_addr;
   logic [N-1:0]         tr_we;
   logic [TAG_LEN-1:0]   tr_din;
   logic [N*TAG_LEN-1:0] tr_dout;
   logic                 rf_req_valid;
   logic                 rf_req_ready = 1'b0;
   logic                 rf_done = 1'b0;
`ifdef CACHE_TAG_STATS_EN
   logic [31:0]          hit_cnt;
   logic [31:0]          miss_cnt;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   int benchHits = 0;
   int benchMisses = 0;

   // Tag RAM that the DUT addresses; read is combinational, write on the clock edge.
   logic [TAG_LEN-1:0] tagRam [H][N];

   // Reference model of the cache contents as seen from the outside.
   logic               refValid [H][N];
   logic [TAG_LEN-1:0] refTag   [H][N];
   int                 refRr;

   typedef struct {
      bit                 doReset;
      logic [LOG_H-1:0]   idx;
      logic [TAG_LEN-1:0] tag;
      int                 readyDelay;
      int                 doneDelay;
      bit                 expHit;
      int                 expWay;
   } vec_t;

   vec_t vecs [12];

   cache_tag_ctrl #(
      .N(N), .LOG_N(LOG_N), .H(H), .LOG_H(LOG_H), .TAG_LEN(TAG_LEN)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_index(req_index),
      .req_tag(req_tag),
      .resp_valid(resp_valid),
      .resp_hit(resp_hit),
      .resp_way(resp_way),
      .tr_addr(tr_addr),
      .tr_we(tr_we),
      .tr_din(tr_din),
      .tr_dout(tr_dout),
      .rf_req_valid(rf_req_valid),
      .rf_req_ready(rf_req_ready),
      .rf_done(rf_done)
`ifdef CACHE_TAG_STATS_EN
      ,
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      tr_dout = '0;
      for (int j = 0; j < N; j++) begin
         tr_dout[j*TAG_LEN +: TAG_LEN] = tagRam[tr_addr][j];
      end
   end

   always @(posedge clk) begin
      for (int j = 0; j < N; j++) begin
         if (tr_we[j]) tagRam[tr_addr][j] <= tr_din;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      for (int s = 0; s < H; s++) begin
         for (int w = 0; w < N; w++) begin
            refValid[s][w] = 1'b0;
            refTag[s][w]   = '0;
         end
      end
      refRr = 0;
   endfunction

   // Hit = lowest valid way whose tag matches; otherwise lowest empty way, otherwise round-robin pointer.
   function automatic void modelPredict(input logic [LOG_H-1:0] idx, input logic [TAG_LEN-1:0] tag,
                                        output bit hit, output int way, output bit fromRr);
      hit = 1'b0;
      way = -1;
      fromRr = 1'b0;
      for (int w = 0; w < N; w++) begin
         if (!hit && refValid[idx][w] && refTag[idx][w] == tag) begin
            hit = 1'b1;
            way = w;
         end
      end
      if (!hit) begin
         for (int w = 0; w < N; w++) begin
            if (way < 0 && !refValid[idx][w]) way = w;
         end
         if (way < 0) begin
            way = refRr;
            fromRr = 1'b1;
         end
      end
   endfunction

   function automatic void modelCommit(input logic [LOG_H-1:0] idx, input logic [TAG_LEN-1:0] tag,
                                       input bit hit, input int way, input bit fromRr);
      if (!hit) begin
         refValid[idx][way] = 1'b1;
         refTag[idx][way]   = tag;
         if (fromRr) refRr = (refRr + 1) % N;
      end
   endfunction

   task automatic resetDut();
      @(negedge clk);
      resetn       = 1'b0;
      req_valid    = 1'b0;
      rf_req_ready = 1'b0;
      rf_done      = 1'b0;
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 0);
      checkOutput("rst_resp_hit", 32'(resp_hit), 0);
      checkOutput("rst_resp_way", 32'(resp_way), 0);
      checkOutput("rst_rf_req_valid", 32'(rf_req_valid), 0);
      checkOutput("rst_tr_we", 32'(tr_we), 0);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_req_ready", 32'(req_ready), 1);
      modelReset();
      benchHits   = 0;
      benchMisses = 0;
   endtask

   // One complete lookup: accept, LOOKUP, then either RESP directly or the refill handshake.
   task automatic applyStimulus(input logic [LOG_H-1:0] idx, input logic [TAG_LEN-1:0] tag,
                                input int readyDelay, input int doneDelay,
                                input bit expHit, input int expWay);
      logic [31:0] expWe;
      expWe = 32'(1) << expWay;
      @(negedge clk);
      checkOutput("idle_req_ready", 32'(req_ready), 1);
      req_valid = 1'b1;
      req_index = idx;
      req_tag   = tag;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("lookup_quiet", {29'd0, resp_valid, rf_req_valid, req_ready}, 0);
      @(negedge clk);
      if (expHit) begin
         checkOutput("hit_resp_valid", 32'(resp_valid), 1);
         checkOutput("hit_resp_hit", 32'(resp_hit), 1);
         checkOutput("hit_resp_way", 32'(resp_way), 32'(expWay));
         checkOutput("hit_no_refill", 32'(rf_req_valid), 0);
         benchHits++;
      end else begin
         checkOutput("miss_rf_req_valid", 32'(rf_req_valid), 1);
         checkOutput("miss_no_resp", 32'(resp_valid), 0);
         for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("stall_rf_req_valid", 32'(rf_req_valid), 1);
            checkOutput("stall_tr_we", 32'(tr_we), 0);
            checkOutput("stall_req_ready", 32'(req_ready), 0);
         end
         rf_req_ready = 1'b1;
         @(posedge clk);
         #1 rf_req_ready = 1'b0;
         for (int i = 0; i < doneDelay; i++) begin
            @(negedge clk);
            checkOutput("wait_rf_req_valid", 32'(rf_req_valid), 0);
            checkOutput("wait_tr_we", 32'(tr_we), 0);
         end
         @(negedge clk);
         rf_done = 1'b1;
         @(posedge clk);
         #1 rf_done = 1'b0;
         @(negedge clk);
         checkOutput("update_tr_we", 32'(tr_we), expWe);
         checkOutput("update_tr_din", 32'(tr_din), 32'(tag));
         checkOutput("update_tr_addr", 32'(tr_addr), 32'(idx));
         @(negedge clk);
         checkOutput("miss_resp_valid", 32'(resp_valid), 1);
         checkOutput("miss_resp_hit", 32'(resp_hit), 0);
         checkOutput("miss_resp_way", 32'(resp_way), 32'(expWay));
         checkOutput("miss_resp_tr_we", 32'(tr_we), 0);
         benchMisses++;
      end
      @(negedge clk);
      checkOutput("resp_pulse_end", 32'(resp_valid), 0);
      checkOutput("hold_resp_hit", 32'(resp_hit), 32'(expHit));
      checkOutput("hold_resp_way", 32'(resp_way), 32'(expWay));
      checkOutput("back_idle_req_ready", 32'(req_ready), 1);
   endtask

   task automatic runModelled(input logic [LOG_H-1:0] idx, input logic [TAG_LEN-1:0] tag,
                              input int readyDelay, input int doneDelay);
      bit hit;
      int way;
      bit fromRr;
      modelPredict(idx, tag, hit, way, fromRr);
      applyStimulus(idx, tag, readyDelay, doneDelay, hit, way);
      modelCommit(idx, tag, hit, way, fromRr);
   endtask

   initial begin
      bit hit;
      int way;
      bit fromRr;

      for (int s = 0; s < H; s++) begin
         for (int w = 0; w < N; w++) tagRam[s][w] = '0;
      end

      vecs[0]  = '{1'b0, 6'd5, 20'h12345, 0,  0, 1'b0, 0};
      vecs[1]  = '{1'b0, 6'd5, 20'h12345, 0,  0, 1'b1, 0};
      vecs[2]  = '{1'b1, 6'd5, 20'h0000A, 1,  2, 1'b0, 0};
      vecs[3]  = '{1'b0, 6'd5, 20'h0000B, 0,  1, 1'b0, 1};
      vecs[4]  = '{1'b0, 6'd5, 20'h0000C, 2,  0, 1'b0, 0};
      vecs[5]  = '{1'b0, 6'd5, 20'h0000D, 0,  0, 1'b0, 1};
      vecs[6]  = '{1'b0, 6'd5, 20'h0000C, 0,  0, 1'b1, 0};
      vecs[7]  = '{1'b0, 6'd5, 20'h0000D, 0,  0, 1'b1, 1};
      vecs[8]  = '{1'b0, 6'd5, 20'h0000A, 0,  0, 1'b0, 0};
      vecs[9]  = '{1'b0, 6'd9, 20'h0000A, 0,  0, 1'b0, 0};
      vecs[10] = '{1'b0, 6'd9, 20'h0000A, 0,  0, 1'b1, 0};
      vecs[11] = '{1'b0, 6'd9, 20'h00077, 10, 3, 1'b0, 1};

      resetDut();

      for (int v = 0; v < 12; v++) begin
         if (vecs[v].doReset) resetDut();
         modelPredict(vecs[v].idx, vecs[v].tag, hit, way, fromRr);
         applyStimulus(vecs[v].idx, vecs[v].tag, vecs[v].readyDelay, vecs[v].doneDelay,
                       vecs[v].expHit, vecs[v].expWay);
         modelCommit(vecs[v].idx, vecs[v].tag, hit, way, fromRr);
      end

      // Reset while waiting for refill data, then a stray rf_done must not write anything.
      @(negedge clk);
      req_valid = 1'b1;
      req_index = 6'd7;
      req_tag   = 20'h00055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort_rf_req_valid", 32'(rf_req_valid), 1);
      rf_req_ready = 1'b1;
      @(posedge clk);
      #1 rf_req_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checkOutput("abort_rst_req_ready", 32'(req_ready), 0);
      checkOutput("abort_rst_tr_we", 32'(tr_we), 0);
      resetn  = 1'b1;
      rf_done = 1'b1;
      #1 checkOutput("abort_stray_done_tr_we", 32'(tr_we), 0);
      @(posedge clk);
      #1 rf_done = 1'b0;
      @(negedge clk);
      checkOutput("abort_after_tr_we", 32'(tr_we), 0);
      checkOutput("abort_after_req_ready", 32'(req_ready), 1);
      checkOutput("abort_after_rf_req_valid", 32'(rf_req_valid), 0);
      modelReset();
      benchHits   = 0;
      benchMisses = 0;
      applyStimulus(6'd7, 20'h00055, 0, 0, 1'b0, 0);
      modelCommit(6'd7, 20'h00055, 1'b0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         runModelled(6'($urandom_range(0, 3)), 20'($urandom_range(1, 5)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

`ifdef CACHE_TAG_STATS_EN
      @(negedge clk);
      checkOutput("rand_hit_cnt", hit_cnt, 32'(benchHits));
      checkOutput("rand_miss_cnt", miss_cnt, 32'(benchMisses));
`endif

      resetDut();
      applyStimulus(6'd1, 20'h00001, 0, 0, 1'b0, 0);
      applyStimulus(6'd1, 20'h00002, 0, 0, 1'b0, 1);
      applyStimulus(6'd1, 20'h00001, 0, 0, 1'b1, 0);
      applyStimulus(6'd1, 20'h00002, 0, 0, 1'b1, 1);
      applyStimulus(6'd1, 20'h00001, 0, 0, 1'b1, 0);
`ifdef CACHE_TAG_STATS_EN
      @(negedge clk);
      checkOutput("stats_hit_cnt", hit_cnt, 32'd3);
      checkOutput("stats_miss_cnt", miss_cnt, 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning number of ways.
REQ-002 The block SHALL have parameter LOG_N, default 1, meaning way-index width, ceil(log2 N).
REQ-003 The block SHALL have parameter H, default 64, meaning number of sets.
REQ-004 The block SHALL have parameter LOG_H, default 6, meaning set-index width.
REQ-005 The block SHALL have parameter TAG_LEN, default 20, meaning tag width.
REQ-006 The block SHALL have port clk, input, width 1: clock, all state on rising edge.
REQ-007 The block SHALL have port resetn, input, width 1: reset, synchronous, active-low.
REQ-008 The block SHALL have the following lookup-request ports:
- req_valid, input, 1.
- req_ready, output, 1.
- req_index, input, LOG_H.
- req_tag, input, TAG_LEN.
REQ-009 The block SHALL have the following response ports:
- resp_valid, output, 1: one-cycle pulse.
- resp_hit, output, 1.
- resp_way, output, LOG_N.
REQ-010 The block SHALL have the following tag-RAM ports:
- tr_addr, output, LOG_H: set address.
- tr_we, output, N: one-hot way write enable.
- tr_din, output, TAG_LEN: write tag.
- tr_dout, input, N*TAG_LEN: combinational read of all ways at tr_addr; way j occupies bits [j*TAG_LEN +: TAG_LEN].
REQ-011 The block SHALL have the following refill ports:
- rf_req_valid, output, 1.
- rf_req_ready, input, 1.
- rf_done, input, 1: single-cycle pulse marking refill data written.

Function
REQ-012 The FSM SHALL have the states IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, UPDATE and RESP.
REQ-013 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, capturing req_index/req_tag into internal registers, next state LOOKUP.
REQ-014 tr_addr SHALL equal the captured index in every state except IDLE, where it equals req_index.
REQ-015 LOOKUP SHALL compare each way: hit_j = valid[index][j] && (tr_dout way j == captured tag); valid bits are internal H*N flops.
REQ-016 On any hit, LOOKUP SHALL go to RESP with resp_hit=1 and resp_way=lowest hitting j; with accept at edge T, resp_valid is high in cycle T+2.
REQ-017 On a miss, LOOKUP SHALL select a victim and go to REFILL_REQ, with the victim being:
- the lowest-numbered invalid way of the set, if any way is invalid;
- otherwise the global round-robin pointer rr.
REQ-018 REFILL_REQ SHALL hold rf_req_valid=1 until rf_req_ready=1, then go to REFILL_WAIT; rf_req_valid SHALL be 0 in all other states.
REQ-019 REFILL_WAIT SHALL wait for rf_done=1, then go to UPDATE; rf_done in any other state SHALL be ignored.
REQ-020 UPDATE SHALL, for exactly one cycle:
- drive tr_we one-hot at the victim and tr_din = captured tag;
- set valid[index][victim];
- advance rr = (rr+1) mod N only if the victim came from rr;
- go to RESP.
REQ-021 tr_we SHALL be all-zero outside UPDATE.
REQ-022 On a miss, RESP SHALL drive resp_hit=0 and resp_way=victim.
REQ-023 RESP SHALL pulse resp_valid for one cycle with no backpressure, then go to IDLE.
REQ-024 Miss latency SHALL be: accept T -> rf_req_valid at T+2 -> UPDATE one cycle after the rf_done edge -> resp_valid the following cycle.
REQ-025 resp_hit and resp_way SHALL hold their last values when resp_valid=0.
REQ-026 rr SHALL wrap from N-1 to 0.

Reset
REQ-027 When resetn=0 at a clock edge, in any state including mid-refill, the block SHALL:
- enter IDLE;
- clear all valid bits;
- set rr=0;
- set resp_valid=0, resp_hit=0, resp_way=0, rf_req_valid=0, tr_we=0.
REQ-028 req_ready SHALL be 0 while resetn=0 and 1 on the first cycle after release.
REQ-029 An rf_done arriving after an aborted refill SHALL be ignored; no tag write results.

Configuration
REQ-030 Macro CACHE_TAG_STATS_EN SHALL, when defined, add the following outputs:
- hit_cnt, output, 32: increments in RESP when resp_hit=1.
- miss_cnt, output, 32: increments in RESP when resp_hit=0.
Both counters wrap at 2^32-1 -> 0 and reset to 0.
REQ-031 Without CACHE_TAG_STATS_EN, the ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 After reset, a lookup of index 5, tag 0x12345 -> the bench SHALL see:
- rf_req_valid at T+2;
- after rf_req_ready then rf_done, tr_we=2'b01 and tr_din=0x12345;
- resp_valid with hit=0, way=0.
REQ-033 Repeating index 5, tag 0x12345 (tag-RAM model updated) -> the bench SHALL see resp_valid at T+2 with hit=1, way=0, and no rf_req_valid.
REQ-034 Misses at index 5 with tags 0xA, 0xB, then 0xC -> the bench SHALL see the victims in this order:
- 0xA -> way 0 (first invalid way);
- 0xB -> way 1 (first invalid way);
- 0xC -> way 0 (rr=0), after which rr=1.
REQ-035 Holding rf_req_ready=0 for 10 cycles on a miss -> the bench SHALL see rf_req_valid steady at 1, tr_we=0 and req_ready=0 throughout.
REQ-036 Asserting resetn=0 during REFILL_WAIT, then pulsing rf_done -> the bench SHALL see:
- no tr_we;
- req_ready=1 after release;
- a lookup of the prior tag misses.
REQ-037 With CACHE_TAG_STATS_EN defined, 3 hits and 2 misses -> the bench SHALL read hit_cnt=3 and miss_cnt=2.
